// File: rtl/ysyx_23060184_pcu_pkg.sv
// rtl/ysyx_23060184_pcu_pkg.sv - shared constants, state encoding and alignment helper for the pcu
package ysyx_23060184_pcu_pkg;

    localparam int          PCU_DATA_WIDTH = 32;
    localparam logic [31:0] PCU_RESET_PC   = 32'h8000_0000;

    // Low address bits that must be zero for a legal 32-bit instruction fetch.
    localparam logic [1:0]  ALIGN_MASK     = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } pcu_state_t;

    // Checks only the low two bits so it works for any address width.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060184_npc_sel.sv
// rtl/ysyx_23060184_npc_sel.sv - next-pc priority mux with redirect alignment check
module ysyx_23060184_npc_sel
    import ysyx_23060184_pcu_pkg::*;
#(
    parameter int DATA_WIDTH = PCU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  trap,
    input  logic                  mret,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  misalign
);

    logic [DATA_WIDTH-1:0] target;
    logic                  redirect;

    // Trap beats mret beats branch beats sequential; only redirects are alignment-checked.
    always_comb begin
        target   = pc + DATA_WIDTH'(4);
        redirect = 1'b0;
        next_pc  = target;
        misalign = 1'b0;
        if (trap) begin
            target   = mtvec;
            redirect = 1'b1;
        end else if (mret) begin
            target   = mepc;
            redirect = 1'b1;
        end else if (br_taken) begin
            target   = br_target;
            redirect = 1'b1;
        end
        if (redirect && is_misaligned(target[1:0])) begin
            next_pc  = mtvec;
            misalign = 1'b1;
        end else begin
            next_pc  = target;
        end
    end

endmodule

// File: rtl/ysyx_23060184_pcu.sv
// rtl/ysyx_23060184_pcu.sv - program-counter unit: issue pc to fetch, await commit, pick next pc
module ysyx_23060184_pcu
    import ysyx_23060184_pcu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PCU_RESET_PC,
    parameter int          DATA_WIDTH = PCU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  pvalid,
    input  logic                  iready,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic                  trap,
    input  logic                  mret,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    output logic                  misalign,
    output logic [63:0]           inst_cnt
);

    pcu_state_t            state;
    pcu_state_t            state_nxt;
    logic                  commit;
    logic [DATA_WIDTH-1:0] sel_pc;
    logic                  sel_misalign;

    ysyx_23060184_npc_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_npc_sel (
        .pc        (pc),
        .trap      (trap),
        .mret      (mret),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mtvec     (mtvec),
        .mepc      (mepc),
        .next_pc   (sel_pc),
        .misalign  (sel_misalign)
    );

    // State register; reset abandons any outstanding fetch or commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, all decoded from the state register only.
    always_comb begin
        state_nxt = state;
        pvalid    = 1'b0;
        wb_ready  = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                pvalid = 1'b1;
                if (iready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    commit    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // PC, retired counter and one-cycle misalign flag all update on the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= DATA_WIDTH'(RESET_PC);
            inst_cnt <= 64'd0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (commit) begin
                pc       <= sel_pc;
                inst_cnt <= inst_cnt + 64'd1;
                misalign <= sel_misalign;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_pcu.sv
// tb/tb_ysyx_23060184_pcu.sv - self-checking bench: vector table, corner sequences, random vs reference model
module tb_ysyx_23060184_pcu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pvalid;
    logic        iready;
    logic        wb_valid;
    logic        wb_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        misalign;
    logic [63:0] inst_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [63:0] m_cnt;

    typedef struct {
        bit          t;
        bit          m;
        bit          b;
        logic [31:0] bt;
        logic [31:0] mtv;
        logic [31:0] mep;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[10];

    ysyx_23060184_pcu dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .pvalid    (pvalid),
        .iready    (iready),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .trap      (trap),
        .mret      (mret),
        .mtvec     (mtvec),
        .mepc      (mepc),
        .misalign  (misalign),
        .inst_cnt  (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: destination chosen by priority, any non-word-aligned redirect falls back to mtvec.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit t, input bit m, input bit b,
                                             input logic [31:0] bt, input logic [31:0] mtv,
                                             input logic [31:0] mep, output bit mis);
        longint unsigned dest;
        mis = 1'b0;
        if (t)      dest = mtv;
        else if (m) dest = mep;
        else if (b) dest = bt;
        else        dest = (longint'(cur) + 4) % 64'h1_0000_0000;
        if ((t || m || b) && (dest % 4) != 0) begin
            mis  = 1'b1;
            dest = mtv;
        end
        return dest[31:0];
    endfunction

    task automatic clear_inputs();
        iready = 0; wb_valid = 0; br_taken = 0; br_target = '0;
        trap = 0; mret = 0; mtvec = '0; mepc = '0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (pvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pvalid_timeout", {63'd0, pvalid}, 64'd1);
        chk("issue_pc", {32'd0, pc}, {32'd0, m_pc});
    endtask

    task automatic issue_handshake();
        wait_issue();
        iready = 1;
        @(negedge clk);
        iready = 0;
        chk("post_xfer_pvalid", {63'd0, pvalid}, 64'd0);
        chk("post_xfer_wb_ready", {63'd0, wb_ready}, 64'd1);
    endtask

    task automatic commit(input bit t, input bit m, input bit b, input logic [31:0] bt,
                          input logic [31:0] mtv, input logic [31:0] mep,
                          input logic [31:0] exp_pc, input bit exp_mis);
        trap = t; mret = m; br_taken = b; br_target = bt; mtvec = mtv; mepc = mep;
        wb_valid = 1;
        @(negedge clk);
        clear_inputs();
        m_pc = exp_pc;
        m_cnt = m_cnt + 64'd1;
        chk("commit_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("commit_misalign", {63'd0, misalign}, {63'd0, exp_mis});
        chk("commit_inst_cnt", inst_cnt, m_cnt);
        chk("commit_pvalid", {63'd0, pvalid}, 64'd1);
        chk("commit_wb_ready", {63'd0, wb_ready}, 64'd0);
        @(negedge clk);
        chk("misalign_one_cycle", {63'd0, misalign}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 0};
        vecs[1] = '{1, 0, 1, 32'h8000_0100, 32'h8000_0400, 32'h0,         32'h8000_0400, 0};
        vecs[2] = '{0, 0, 1, 32'h8000_0102, 32'h8000_0400, 32'h0,         32'h8000_0400, 1};
        vecs[3] = '{0, 1, 1, 32'h8000_0200, 32'h8000_0300, 32'h8000_0010, 32'h8000_0010, 0};
        vecs[4] = '{0, 1, 0, 32'h0,         32'h8000_0200, 32'h8000_0011, 32'h8000_0200, 1};
        vecs[5] = '{0, 0, 1, 32'h8000_0020, 32'h8000_0500, 32'h8000_0600, 32'h8000_0020, 0};
        vecs[6] = '{0, 0, 0, 32'h8000_0700, 32'h8000_0500, 32'h8000_0600, 32'h8000_0024, 0};
        vecs[7] = '{1, 1, 1, 32'h8000_0800, 32'h8000_0402, 32'h8000_0900, 32'h8000_0402, 1};
        vecs[8] = '{0, 0, 1, 32'hFFFF_FFFC, 32'h8000_0400, 32'h0,         32'hFFFF_FFFC, 0};
        vecs[9] = '{0, 0, 0, 32'h0,         32'h8000_0400, 32'h0,         32'h0000_0000, 0};

        clear_inputs();
        iready = 1;
        reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_pc", {32'd0, pc}, 64'h8000_0000);
        chk("rst_pvalid", {63'd0, pvalid}, 64'd0);
        chk("rst_wb_ready", {63'd0, wb_ready}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        chk("rst_inst_cnt", inst_cnt, 64'd0);

        reset = 0;
        chk("boot_pvalid", {63'd0, pvalid}, 64'd0);
        @(negedge clk);
        chk("first_pvalid", {63'd0, pvalid}, 64'd1);
        chk("first_pc", {32'd0, pc}, 64'h8000_0000);
        @(negedge clk);
        iready = 0;
        chk("first_xfer_pvalid", {63'd0, pvalid}, 64'd0);
        chk("first_xfer_wb_ready", {63'd0, wb_ready}, 64'd1);
        m_pc = 32'h8000_0000;
        m_cnt = 0;

        for (int i = 0; i < 10; i++) begin
            if (i != 0) issue_handshake();
            commit(vecs[i].t, vecs[i].m, vecs[i].b, vecs[i].bt, vecs[i].mtv, vecs[i].mep,
                   vecs[i].exp_pc, vecs[i].exp_mis);
        end

        // Fetch stalled: pc and pvalid hold, stray commits are ignored.
        for (int k = 0; k < 10; k++) begin
            wb_valid = k[0];
            trap = 1;
            mtvec = 32'h8000_0A00;
            @(negedge clk);
            chk("stall_pc", {32'd0, pc}, {32'd0, m_pc});
            chk("stall_pvalid", {63'd0, pvalid}, 64'd1);
            chk("stall_wb_ready", {63'd0, wb_ready}, 64'd0);
            chk("stall_inst_cnt", inst_cnt, m_cnt);
        end
        clear_inputs();

        for (int n = 0; n < 150; n++) begin
            bit          t, m, b, mis;
            logic [31:0] bt, mtv, mep, exp;
            repeat ($urandom_range(0, 3)) begin
                wb_valid = $urandom_range(0, 1);
                @(negedge clk);
                chk("rnd_hold_pc", {32'd0, pc}, {32'd0, m_pc});
                chk("rnd_hold_cnt", inst_cnt, m_cnt);
            end
            wb_valid = 0;
            issue_handshake();
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rnd_wait_wb_ready", {62'd0, wb_ready, pvalid}, 64'd2);
            end
            t = ($urandom_range(0, 5) == 0);
            m = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 1) == 1);
            bt = $urandom; mtv = $urandom; mep = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) mep[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) mtv[1:0] = 2'b00;
            exp = ref_next(m_pc, t, m, b, bt, mtv, mep, mis);
            commit(t, m, b, bt, mtv, mep, exp, mis);
        end

        // Reset while waiting for commit.
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_pc = 32'h8000_0000;
        m_cnt = 0;
        issue_handshake(); commit(0, 0, 0, 0, 0, 0, 32'h8000_0004, 0);
        issue_handshake(); commit(0, 0, 0, 0, 0, 0, 32'h8000_0008, 0);
        issue_handshake(); commit(0, 0, 1, 32'h8000_0008, 32'h8000_0400, 0, 32'h8000_0008, 0);
        issue_handshake(); commit(0, 0, 0, 0, 0, 0, 32'h8000_000C, 0);
        issue_handshake(); commit(0, 0, 0, 0, 0, 0, 32'h8000_0010, 0);
        issue_handshake();
        chk("pre_rst_pc", {32'd0, pc}, 64'h8000_0010);
        chk("pre_rst_cnt", inst_cnt, 64'd5);
        #1 reset = 1;
        #1;
        chk("async_rst_pc", {32'd0, pc}, 64'h8000_0000);
        chk("async_rst_cnt", inst_cnt, 64'd0);
        chk("async_rst_pvalid", {63'd0, pvalid}, 64'd0);
        chk("async_rst_wb_ready", {63'd0, wb_ready}, 64'd0);
        @(negedge clk);
        reset = 0;
        m_pc = 32'h8000_0000;
        m_cnt = 0;
        @(negedge clk);
        chk("rerun_pvalid", {63'd0, pvalid}, 64'd1);
        chk("rerun_pc", {32'd0, pc}, 64'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
